// File: rtl/uart_pkg.sv
// Shared UART definitions: default divisor widths, the baud divisor calculator and
// the oversample legality check.
package uart_pkg;

  localparam int BAUD_DIV_W  = 16;
  localparam int BAUD_FRAC_W = 8;

  typedef struct packed {
    logic [31:0] int_part;
    logic [31:0] frac_part;
  } baud_div_t;

  // Integer part is floor(clk/(baud*os)); the remainder is rounded into frac_w bits and
  // saturated so that it never rolls into the integer part.
  function automatic baud_div_t calc_baud_div(input longint clk_freq, input longint baud,
                                              input longint os, input int frac_w = BAUD_FRAC_W);
    baud_div_t r;
    longint    dv, rem, one, frac;
    dv   = baud * os;
    one  = longint'(1) << frac_w;
    rem  = clk_freq % dv;
    frac = (rem * one + dv / 2) / dv;
    if (frac > one - 1) frac = one - 1;
    r.int_part  = 32'(clk_freq / dv);
    r.frac_part = 32'(frac);
    return r;
  endfunction

  function automatic bit os_legal(input int os);
    return (os >= 4) && (os <= 16) && ((os & (os - 1)) == 0);
  endfunction

endpackage

// File: rtl/baud_frac_div.sv
// Fractional period counter: cnt runs 0..P-1 with P = div_int + carry, where carry is
// the overflow of a fractional accumulator stepped once per rx_tick.
module baud_frac_div
  import uart_pkg::*;
#(
  parameter int DIV_W  = BAUD_DIV_W,
  parameter int FRAC_W = BAUD_FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sync,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] frac_next,
  output logic              tick
);

  logic [DIV_W-1:0]  cnt;
  logic [FRAC_W-1:0] acc;
  logic              carry;
  logic [DIV_W:0]    p_last;
  logic [FRAC_W:0]   acc_sum;

  // P can be 2^DIV_W, so the terminal compare is one bit wider than cnt.
  assign p_last  = {1'b0, div_int} + {{DIV_W{1'b0}}, carry} - (DIV_W+1)'(1);
  assign acc_sum = {1'b0, acc} + {1'b0, frac_next};
  assign tick    = en && !sync && !rst && ({1'b0, cnt} == p_last);

  always_ff @(posedge clk) begin
    if (rst || !en || sync) begin
      cnt   <= '0;
      acc   <= '0;
      carry <= 1'b0;
    end else if (tick) begin
      cnt   <= '0;
      acc   <= acc_sum[FRAC_W-1:0];
      carry <= acc_sum[FRAC_W];
    end else begin
      cnt   <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// Programmable baud tick generator (rx oversample tick, mid-bit and tx bit ticks).
// Optional BAUD_CLK_OUT_EN adds a legacy square-wave baud_clk output.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLK_FREQ     = 50000000,
  parameter int DEFAULT_BAUD = 9600,
  parameter int OVERSAMPLE   = 16,
  parameter int DIV_W        = BAUD_DIV_W,
  parameter int FRAC_W       = BAUD_FRAC_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              div_wr,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              rx_sync,
  output logic              div_pend,
  output logic              cfg_err,
  output logic              rx_tick,
  output logic              rx_mid,
`ifdef BAUD_CLK_OUT_EN
  output logic              baud_clk,
`endif
  output logic              tx_tick
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam baud_div_t DEF_DIV = calc_baud_div(CLK_FREQ, DEFAULT_BAUD, OVERSAMPLE, FRAC_W);
  localparam logic [DIV_W-1:0]  DEF_INT  = DEF_DIV.int_part[DIV_W-1:0];
  localparam logic [FRAC_W-1:0] DEF_FRAC = DEF_DIV.frac_part[FRAC_W-1:0];

  if (!os_legal(OVERSAMPLE)) begin : g_bad_os
    $error("OVERSAMPLE must be a power of 2 in 4..16");
  end

  logic [DIV_W-1:0]  sh_int, act_int;
  logic [FRAC_W-1:0] sh_frac, act_frac, frac_next;
  logic [OS_W-1:0]   os_cnt;
  logic              wr_ok, xfer;

  assign wr_ok = div_wr && (div_int > DIV_W'(1));
  assign xfer  = rx_tick && div_pend;
  // The accumulator step at a transfer tick uses the fraction of the divisor that
  // governs the coming period, so the new rate starts clean.
  assign frac_next = xfer ? sh_frac : act_frac;

  baud_frac_div #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .en        (enable),
    .sync      (rx_sync),
    .div_int   (act_int),
    .frac_next (frac_next),
    .tick      (rx_tick)
  );

  assign tx_tick = rx_tick && (os_cnt == OS_LAST);
  assign rx_mid  = rx_tick && (os_cnt == OS_MID);

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_int   <= DEF_INT;
      sh_frac  <= DEF_FRAC;
      act_int  <= DEF_INT;
      act_frac <= DEF_FRAC;
      div_pend <= 1'b0;
      cfg_err  <= 1'b0;
      os_cnt   <= '0;
    end else begin
      cfg_err <= div_wr && !wr_ok;
      if (wr_ok) begin
        sh_int  <= div_int;
        sh_frac <= div_frac;
      end
      if (!enable) begin
        // Idle: no period to finish, so writes land in the active divisor at once.
        os_cnt   <= '0;
        div_pend <= 1'b0;
        if (wr_ok) begin
          act_int  <= div_int;
          act_frac <= div_frac;
        end else if (div_pend) begin
          act_int  <= sh_int;
          act_frac <= sh_frac;
        end
      end else begin
        if (rx_sync)      os_cnt <= '0;
        else if (rx_tick) os_cnt <= os_cnt + OS_W'(1);
        if (xfer) begin
          act_int  <= sh_int;
          act_frac <= sh_frac;
        end
        if (wr_ok)     div_pend <= 1'b1;
        else if (xfer) div_pend <= 1'b0;
      end
    end
  end

`ifdef BAUD_CLK_OUT_EN
  always_ff @(posedge clk) begin
    if (rst || !enable)
      baud_clk <= 1'b1;
    else if (rx_tick && ((os_cnt == OS_MID) || (os_cnt == OS_LAST)))
      baud_clk <= ~baud_clk;
  end
`endif

endmodule
